instr_word_encoder: RTL
=======================

Name: instr_word_encoder

Overview:
Encoder counterpart of the single-cycle control decoder. It accepts symbolic instruction requests (operation plus register and immediate fields) over a valid/ready handshake. It packs each request into a 32-bit MIPS word for the same nine-instruction subset and writes the words sequentially into instruction memory. Used as the on-chip program loader ahead of the single-cycle core and by the verification benches.

Parameters:
ADDR_W, 8, width of the instruction-memory word address.
DEPTH, 256, capacity in words; must satisfy 1 <= DEPTH <= 2**ADDR_W.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  reset, synchronous and active-high.
start  in  1  pulse; begin a new program at address 0.
finish  in  1  pulse; end the current program.
req_valid  in  1  request present.
req_ready  out  1  encoder can accept a request this cycle.
req_op  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 LW, 7 SW, 8 BEQ; 9-15 illegal.
req_rs  in  5  source register rs.
req_rt  in  5  rt (second source for R-type and BEQ, destination for ADDI and LW, data register for SW).
req_rd  in  5  destination register rd (R-type only).
req_imm  in  16  immediate, offset, or branch word offset; passed through unchanged.
wr_en  out  1  instruction-memory write strobe.
wr_addr  out  ADDR_W  write address.
wr_data  out  32  encoded instruction word.
done  out  1  high while in DONE.
prog_len  out  ADDR_W+1  number of words written since the last start.
err_illegal  out  1  sticky; set when an illegal op is accepted.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: req_ready, wr_en, wr_addr, wr_data, done, prog_len, err_illegal.
  - Reset overrides any transfer in flight; a pending write is dropped.
- FSM states and transitions:
  - IDLE: req_ready=0. start moves to RUN.
  - RUN: req_ready=1. finish moves to DONE. Accepting the word at address DEPTH-1 moves to DONE.
  - DONE: req_ready=0, done=1. start moves to RUN.
- Entering RUN clears the write address counter, prog_len and err_illegal.
- Accept condition: req_valid && req_ready.
- Write timing, legal op: exactly one cycle after acceptance, wr_en=1, wr_addr = counter value at acceptance, and wr_data = the encoded word. The address counter and prog_len increment on the accept edge. wr_en is a one-cycle pulse per accepted word.
- Illegal op (9-15): the request is consumed, err_illegal is set, and there is no write and no counter advance.
- Encoding:
  - R-type: opcode 0x00 | rs | rt | rd | shamt 0 | funct. Funct values: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
  - I-type: opcode | rs | rt | imm. Opcodes: ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04.
  - req_rd is ignored for I-type.
- Same-cycle events:
  - finish and an accept in the same cycle: the accepted word is still written on the next cycle, then the FSM is in DONE.
  - start while in RUN restarts: counter goes to 0 and err_illegal is cleared. An accept in that same cycle is discarded.
  - start and finish together: start wins.
- Full boundary: when prog_len reaches DEPTH, the FSM is in DONE and req_ready is 0. The address never wraps.
- done asserts in the cycle after the last write strobe, or in the cycle after finish if no write is pending.

Decomposition:
- Shared package holds:
  - opcode and funct constants, identical to those the control decoder uses;
  - req_op enumeration;
  - FSM state typedef.
- One combinational sub-module, instr_pack, maps (op, rs, rt, rd, imm) to (word, illegal). The top level holds the FSM, counters and the output register.

Test Plan:
- Reset then start, then send ADD rs=1 rt=2 rd=3 -> one cycle after accept: wr_en=1, wr_addr=0, wr_data=0x00221820; prog_len=1.
- Back-to-back requests ADDI(rs0,rt1,imm5), LW(1,2,4), SW(1,2,8), BEQ(1,2,0xFFFF), SLT(rs1,rt2,rd4) -> words 0x20010005, 0x8C220004, 0xAC220008, 0x1022FFFF, 0x0022202A at addresses 0-4, one per cycle.
- Illegal op 12 between two ADDs -> err_illegal=1; the ADDs land at addresses 0 and 1 with no gap write; prog_len=2.
- DEPTH=4, send 6 requests with req_valid held high -> exactly 4 writes (addresses 0-3), req_ready drops, done=1, prog_len=4.
- finish in the same cycle as an accept -> that word is written next cycle, then done=1 and req_ready=0. A subsequent start -> writes restart at address 0.
- rst asserted the cycle after an accept -> no wr_en pulse; all outputs 0 on the next cycle.

Source files
------------

// File: rtl/instr_word_encoder_pkg.sv
// Shared constants and types for the instruction word encoder.
// Opcode and funct values match the single-cycle control decoder.
package instr_word_encoder_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [3:0] {
    REQ_ADD  = 4'd0,
    REQ_SUB  = 4'd1,
    REQ_AND  = 4'd2,
    REQ_OR   = 4'd3,
    REQ_SLT  = 4'd4,
    REQ_ADDI = 4'd5,
    REQ_LW   = 4'd6,
    REQ_SW   = 4'd7,
    REQ_BEQ  = 4'd8
  } req_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/instr_word_encoder_if.sv
// Request handshake and instruction-memory write bus of the encoder.
// The slave modport is the encoder's view; master is the requester/memory side.
interface instr_word_encoder_if #(
  parameter int ADDR_W = 8
);

  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [15:0]       req_imm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_imm,
    output req_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_imm,
    input  req_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/instr_word_encoder_instr_pack.sv
// Combinational packer: symbolic request fields to a 32-bit MIPS word.
// Ops outside the nine-instruction subset flag illegal and yield a zero word.
module instr_pack
  import instr_word_encoder_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (req_op_e'(op))
      REQ_ADD:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADD};
      REQ_SUB:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_SUB};
      REQ_AND:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_AND};
      REQ_OR:   word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_OR};
      REQ_SLT:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_SLT};
      REQ_ADDI: word = {OPC_ADDI, rs, rt, imm};
      REQ_LW:   word = {OPC_LW, rs, rt, imm};
      REQ_SW:   word = {OPC_SW, rs, rt, imm};
      REQ_BEQ:  word = {OPC_BEQ, rs, rt, imm};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_word_encoder.sv
// Program loader: accepts instruction requests, encodes them and writes
// them to consecutive instruction-memory addresses starting at 0.
module instr_word_encoder
  import instr_word_encoder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 finish,
  instr_word_encoder_if.slave  bus,
  output logic                 done,
  output logic [ADDR_W:0]      prog_len,
  output logic                 err_illegal
);

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

  state_e            state, state_next;
  logic [ADDR_W:0]   cnt;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              err_q;
  logic [31:0]       packed_word;
  logic              packed_illegal;
  logic              accept;

  instr_pack u_pack (
    .op      (bus.req_op),
    .rs      (bus.req_rs),
    .rt      (bus.req_rt),
    .rd      (bus.req_rd),
    .imm     (bus.req_imm),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  assign accept = bus.req_valid && bus.req_ready;

  // start beats finish; a legal accept at the last address closes the program
  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        bus.req_ready = 1'b1;
        if (start)
          state_next = ST_RUN;
        else if (finish)
          state_next = ST_DONE;
        else if (accept && !packed_illegal && cnt == LAST_ADDR)
          state_next = ST_DONE;
      end
      ST_DONE: begin
        if (start) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A restart discards any request handshaken in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state   <= state_next;
      wr_en_q <= 1'b0;
      if (start) begin
        cnt   <= '0;
        err_q <= 1'b0;
      end else if (accept) begin
        if (packed_illegal) begin
          err_q <= 1'b1;
        end else begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= cnt[ADDR_W-1:0];
          wr_data_q <= packed_word;
          cnt       <= cnt + CNT_ONE;
        end
      end
    end
  end

  // done waits out the final write strobe when DONE was entered with one pending
  assign done        = (state == ST_DONE) && !wr_en_q;
  assign prog_len    = cnt;
  assign err_illegal = err_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule
